// File: rtl/regfile_2r1w.sv
// General-purpose register file: one synchronous write port and two registered read ports.
// Register 0 reads as zero. A read on the same edge as a write to that register returns the
// new data.
module regfile_2r1w #(
   parameter int unsigned WIDTH = 32,
   parameter int unsigned AW    = 5,
   parameter int unsigned NREGS = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             wr_en,
   input  logic [AW-1:0]    wr_addr,
   input  logic [WIDTH-1:0] wr_data,
   input  logic             rd_en_a,
   input  logic [AW-1:0]    rd_addr_a,
   output logic [WIDTH-1:0] rd_data_a,
   output logic             rd_valid_a,
   input  logic             rd_en_b,
   input  logic [AW-1:0]    rd_addr_b,
   output logic [WIDTH-1:0] rd_data_b,
   output logic             rd_valid_b
);

   // Register 0 has no storage; addresses at or above NREGS match no entry.
   logic [WIDTH-1:0] regs_q [1:NREGS-1];
   logic [WIDTH-1:0] rd_val_a, rd_val_b;

   function automatic logic [WIDTH-1:0] read_value(input logic [AW-1:0] addr);
      logic [WIDTH-1:0] val;
      val = '0;
      for (int unsigned i = 1; i < NREGS; i++) begin
         if (addr == AW'(i)) begin
            val = (wr_en && (wr_addr == addr)) ? wr_data : regs_q[i];
         end
      end
      return val;
   endfunction

   always_comb begin
      rd_val_a = read_value(rd_addr_a);
      rd_val_b = read_value(rd_addr_b);
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int unsigned i = 1; i < NREGS; i++) begin
            regs_q[i] <= '0;
         end
      end else begin
         for (int unsigned i = 1; i < NREGS; i++) begin
            if (wr_en && (wr_addr == AW'(i))) begin
               regs_q[i] <= wr_data;
            end
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         rd_data_a  <= '0;
         rd_valid_a <= 1'b0;
         rd_data_b  <= '0;
         rd_valid_b <= 1'b0;
      end else begin
         rd_valid_a <= rd_en_a;
         rd_valid_b <= rd_en_b;
         if (rd_en_a) begin
            rd_data_a <= rd_val_a;
         end
         if (rd_en_b) begin
            rd_data_b <= rd_val_b;
         end
      end
   end

endmodule

// File: tb/tb_regfile_2r1w.sv
// Self-checking bench for regfile_2r1w: an array-based reference model compared every cycle,
// plus directed checks against hand-computed values.
module tb_regfile_2r1w;
   localparam int unsigned WIDTH = 32;
   localparam int unsigned AW    = 5;
   localparam int unsigned NREGS = 32;

   logic             clk = 1'b0;
   logic             reset = 1'b1;
   logic             wr_en = 1'b0;
   logic [AW-1:0]    wr_addr = '0;
   logic [WIDTH-1:0] wr_data = '0;
   logic             rd_en_a = 1'b0;
   logic [AW-1:0]    rd_addr_a = '0;
   logic [WIDTH-1:0] rd_data_a;
   logic             rd_valid_a;
   logic             rd_en_b = 1'b0;
   logic [AW-1:0]    rd_addr_b = '0;
   logic [WIDTH-1:0] rd_data_b;
   logic             rd_valid_b;

   int total = 0;
   int bad = 0;
   bit cmp_on = 1'b0;

   regfile_2r1w #(.WIDTH(WIDTH), .AW(AW), .NREGS(NREGS)) dut (
      .clk(clk), .reset(reset),
      .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
      .rd_en_a(rd_en_a), .rd_addr_a(rd_addr_a), .rd_data_a(rd_data_a), .rd_valid_a(rd_valid_a),
      .rd_en_b(rd_en_b), .rd_addr_b(rd_addr_b), .rd_data_b(rd_data_b), .rd_valid_b(rd_valid_b)
   );

   always #5 clk = ~clk;

   // Reference model: plain array of register contents plus expected output values.
   logic [WIDTH-1:0] mem [NREGS];
   logic [WIDTH-1:0] exp_a, exp_b;
   logic             exp_va, exp_vb;

   function automatic logic [WIDTH-1:0] model_value(input int addr);
      if (addr == 0 || addr >= int'(NREGS)) return '0;
      if (wr_en && int'(wr_addr) == addr) return wr_data;
      return mem[addr];
   endfunction

   always @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < int'(NREGS); i++) mem[i] <= '0;
         exp_a <= '0; exp_b <= '0; exp_va <= 1'b0; exp_vb <= 1'b0;
      end else begin
         if (rd_en_a) exp_a <= model_value(int'(rd_addr_a));
         if (rd_en_b) exp_b <= model_value(int'(rd_addr_b));
         exp_va <= rd_en_a;
         exp_vb <= rd_en_b;
         if (wr_en && wr_addr != 0 && int'(wr_addr) < int'(NREGS)) mem[wr_addr] <= wr_data;
      end
   end

   task automatic chk(input string name, input logic [WIDTH-1:0] act, input logic [WIDTH-1:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, req, $time);
      end
   endtask

   always @(negedge clk) begin
      if (cmp_on) begin
         chk("cmp_data_a", rd_data_a, exp_a);
         chk("cmp_valid_a", {31'd0, rd_valid_a}, {31'd0, exp_va});
         chk("cmp_data_b", rd_data_b, exp_b);
         chk("cmp_valid_b", {31'd0, rd_valid_b}, {31'd0, exp_vb});
      end
   end

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic idle();
      wr_en = 1'b0; rd_en_a = 1'b0; rd_en_b = 1'b0;
   endtask

   task automatic wr(input int addr, input logic [WIDTH-1:0] data);
      wr_en = 1'b1; wr_addr = AW'(addr); wr_data = data;
   endtask

   initial begin
      #1 reset = 1'b0;
      @(negedge clk);
      @(negedge clk);
      chk("reset_data_a", rd_data_a, 32'd0);
      chk("reset_valid_a", {31'd0, rd_valid_a}, 32'd0);
      chk("reset_data_b", rd_data_b, 32'd0);
      reset = 1'b1;
      cmp_on = 1'b1;

      // 1: reads straight after reset
      rd_en_a = 1'b1; rd_addr_a = 5'd7; rd_en_b = 1'b1; rd_addr_b = 5'd31;
      tick();
      chk("t1_data_a", rd_data_a, 32'd0);
      chk("t1_valid_a", {31'd0, rd_valid_a}, 32'd1);
      chk("t1_data_b", rd_data_b, 32'd0);
      chk("t1_valid_b", {31'd0, rd_valid_b}, 32'd1);
      idle();

      // 2: write then read
      wr(5, 32'd88);
      tick();
      idle(); rd_en_a = 1'b1; rd_addr_a = 5'd5;
      tick();
      chk("t2_data_a", rd_data_a, 32'd88);
      chk("t2_model_a", exp_a, 32'd88);
      chk("t2_valid_a", {31'd0, rd_valid_a}, 32'd1);
      idle();
      tick();
      chk("t2_valid_drop", {31'd0, rd_valid_a}, 32'd0);

      // 3: read before write, then write-first bypass
      rd_en_b = 1'b1; rd_addr_b = 5'd9;
      tick();
      chk("t3_old_b", rd_data_b, 32'd0);
      rd_en_b = 1'b0;
      wr(9, 32'd90); rd_en_a = 1'b1; rd_addr_a = 5'd9;
      tick();
      chk("t3_bypass_a", rd_data_a, 32'd90);
      idle();

      // 4: register 0 stays zero; wr_en=0 writes nothing
      wr(0, 32'hDEADBEEF);
      tick();
      idle(); rd_en_a = 1'b1; rd_addr_a = 5'd0; rd_en_b = 1'b1; rd_addr_b = 5'd0;
      tick();
      chk("t4_r0_a", rd_data_a, 32'd0);
      chk("t4_r0_b", rd_data_b, 32'd0);
      idle(); wr_addr = 5'd5; wr_data = 32'd89;
      tick();
      rd_en_a = 1'b1; rd_addr_a = 5'd5;
      tick();
      chk("t4_no_write", rd_data_a, 32'd88);

      // back-to-back reads give back-to-back valids
      rd_addr_a = 5'd9;
      tick();
      chk("b2b_data", rd_data_a, 32'd90);
      chk("b2b_valid", {31'd0, rd_valid_a}, 32'd1);

      // 5: hold behaviour
      rd_addr_a = 5'd5;
      tick();
      idle();
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("t5_hold", rd_data_a, 32'd88);
         chk("t5_valid_low", {31'd0, rd_valid_a}, 32'd0);
      end

      // 6: fill, then async reset mid-cycle
      for (int i = 1; i < 32; i++) begin
         wr(i, WIDTH'(100 + i));
         tick();
      end
      idle(); rd_en_a = 1'b1; rd_addr_a = 5'd17; rd_en_b = 1'b1; rd_addr_b = 5'd31;
      tick();
      chk("t6_fill_a", rd_data_a, 32'd117);
      chk("t6_fill_b", rd_data_b, 32'd131);
      rd_addr_a = 5'd20;
      @(posedge clk);
      #2 reset = 1'b0;
      #1;
      chk("t6_async_data", rd_data_a, 32'd0);
      chk("t6_async_valid", {31'd0, rd_valid_a}, 32'd0);
      chk("t6_async_data_b", rd_data_b, 32'd0);
      @(negedge clk);
      tick();
      reset = 1'b1;
      for (int i = 1; i < 32; i++) begin
         rd_en_a = 1'b1; rd_addr_a = AW'(i); rd_en_b = 1'b1; rd_addr_b = AW'(32 - i);
         tick();
         chk("t6_cleared_a", rd_data_a, 32'd0);
         chk("t6_cleared_b", rd_data_b, 32'd0);
      end
      idle();
      tick();
      cmp_on = 1'b0;

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end
endmodule
